// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between icache and dcache; 1-entry buffer per port, strobe 1 cycle after capture, one read outstanding.
// Ties use DC_PRIO by default; define MEM_ARB_ROUND_ROBIN_EN to alternate between ports on ties instead.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter bit DC_PRIO = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_ic_mem_ready,
  input  logic [ADDR_W-1:0] i_ic_mem_addr,
  input  logic              i_ic_mem_ren,
  input  logic              i_ic_mem_wen,
  input  logic [DATA_W-1:0] i_ic_mem_wdata,
  output logic [DATA_W-1:0] o_ic_mem_rdata,
  output logic              o_ic_mem_valid,
  output logic              o_dc_mem_ready,
  input  logic [ADDR_W-1:0] i_dc_mem_addr,
  input  logic              i_dc_mem_ren,
  input  logic              i_dc_mem_wen,
  input  logic [DATA_W-1:0] i_dc_mem_wdata,
  output logic [DATA_W-1:0] o_dc_mem_rdata,
  output logic              o_dc_mem_valid,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_ren,
  output logic              o_mem_wen,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_valid
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t state, state_nxt;
  logic owner, owner_nxt;            // 1 = dcache
  logic last_grant, last_grant_nxt;  // 1 = dcache

  logic              ic_full, dc_full;
  logic [ADDR_W-1:0] ic_addr, dc_addr;
  logic              ic_wen, dc_wen;
  logic [DATA_W-1:0] ic_wdata, dc_wdata;

  logic issue, pick_dc, pick_wen, tie_dc;

  assign o_ic_mem_ready = ~ic_full;
  assign o_dc_mem_ready = ~dc_full;
  assign o_ic_mem_rdata = i_mem_rdata;
  assign o_dc_mem_rdata = i_mem_rdata;
  assign o_ic_mem_valid = (state == RD_WAIT) && !owner && i_mem_valid;
  assign o_dc_mem_valid = (state == RD_WAIT) && owner && i_mem_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign tie_dc = ~last_grant;
`else
  assign tie_dc = DC_PRIO;
`endif

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    issue          = 1'b0;
    pick_dc        = 1'b0;
    pick_wen       = 1'b0;
    case (state)
      IDLE: begin
        if (i_mem_ready && (ic_full || dc_full)) begin
          issue          = 1'b1;
          pick_dc        = (ic_full && dc_full) ? tie_dc : dc_full;
          pick_wen       = pick_dc ? dc_wen : ic_wen;
          last_grant_nxt = pick_dc;
          if (!pick_wen) begin
            state_nxt = RD_WAIT;
            owner_nxt = pick_dc;
          end
        end
      end
      RD_WAIT: begin
        if (i_mem_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      owner      <= 1'b1;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Issue clears only a full buffer and capture only fills an empty one, so they never collide.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ic_full     <= 1'b0;
      ic_addr     <= '0;
      ic_wen      <= 1'b0;
      ic_wdata    <= '0;
      dc_full     <= 1'b0;
      dc_addr     <= '0;
      dc_wen      <= 1'b0;
      dc_wdata    <= '0;
      o_mem_ren   <= 1'b0;
      o_mem_wen   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      o_mem_ren <= issue && !pick_wen;
      o_mem_wen <= issue && pick_wen;
      if (issue) begin
        o_mem_addr  <= pick_dc ? dc_addr : ic_addr;
        o_mem_wdata <= pick_dc ? dc_wdata : ic_wdata;
      end

      if (issue && !pick_dc) begin
        ic_full <= 1'b0;
      end else if (!ic_full && (i_ic_mem_ren || i_ic_mem_wen)) begin
        ic_full  <= 1'b1;
        ic_addr  <= i_ic_mem_addr;
        ic_wen   <= i_ic_mem_wen;
        ic_wdata <= i_ic_mem_wdata;
      end

      if (issue && pick_dc) begin
        dc_full <= 1'b0;
      end else if (!dc_full && (i_dc_mem_ren || i_dc_mem_wen)) begin
        dc_full  <= 1'b1;
        dc_addr  <= i_dc_mem_addr;
        dc_wen   <= i_dc_mem_wen;
        dc_wdata <= i_dc_mem_wdata;
      end
    end
  end

endmodule
